nn_train_seq: RTL
=================

Name: nn_train_seq

Overview:
Training sequencer for the backpropagation neural network datapath. It drives the select_initial / select_update controls shared by all weight and bias registers. It also steps the forward and backward phases of the datapath and walks the training-sample index over a fixed number of epochs. It sits above the weight-register bank and the forward/backward arithmetic, below the top-level start/done interface.

Parameters:
N_SAMPLES, 4, training samples per epoch (>=1)
N_EPOCHS, 1000, epochs per run (>=1)
FWD_CYCLES, 3, clock cycles the forward phase is held (>=1)
BWD_CYCLES, 4, clock cycles the backward/delta phase is held (>=1)
SAMPLE_W, 2, width of sample_idx (2^SAMPLE_W >= N_SAMPLES)
EPOCH_W, 10, width of epoch_idx (2^EPOCH_W >= N_EPOCHS)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
start  in  1  begin a run; sampled only in IDLE
stop  in  1  abort the run; sampled in every non-IDLE state
select_initial  out  1  load initial weights (to all weight registers)
select_update  out  1  accumulate delta weights (to all weight registers)
fwd_en  out  1  forward phase active
bwd_en  out  1  backward phase active
sample_idx  out  SAMPLE_W  current training-sample index
epoch_idx  out  EPOCH_W  current epoch index
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a run completes normally

Behaviour:
- Reset is asynchronous and active-high. On reset, state=IDLE and all outputs are 0, including sample_idx, epoch_idx and the phase counter. Reset mid-run abandons the run; no select_update is issued afterwards.
- All outputs are registered Moore decodes of the state and counters. They change only on a clk rising edge.
- States are IDLE, INIT, FWD, BWD, UPD and DONE.
- IDLE: start=1 moves to INIT on the next edge; otherwise stay in IDLE. start/stop=1 together in IDLE: stay in IDLE.
- INIT (1 cycle):
  - select_initial=1.
  - sample_idx=0, epoch_idx=0.
  - Next state is FWD, with phase counter loaded to FWD_CYCLES-1.
- FWD (FWD_CYCLES cycles):
  - fwd_en=1.
  - Phase counter decrements each cycle.
  - At 0, go to BWD with counter loaded to BWD_CYCLES-1.
- BWD (BWD_CYCLES cycles): bwd_en=1, same counting; at 0, go to UPD.
- UPD (1 cycle): select_update=1. Next state:
  - sample_idx < N_SAMPLES-1: sample_idx+1, go to FWD.
  - Otherwise, if epoch_idx < N_EPOCHS-1: sample_idx=0, epoch_idx+1, go to FWD.
  - Otherwise go to DONE. sample_idx and epoch_idx hold their final values.
- DONE (1 cycle): done=1, busy=1; next state IDLE. start during DONE is ignored.
- Run length: start sampled at edge 0 gives INIT in cycle 1 and DONE in cycle 2 + N_EPOCHS*N_SAMPLES*(FWD_CYCLES+BWD_CYCLES+1).
- stop=1 in INIT/FWD/BWD/UPD/DONE:
  - Next edge goes to IDLE and clears both indices; done stays 0.
  - If UPD is current when stop is sampled, that UPD cycle's select_update pulse has already occurred. The index increment is discarded.
- Mutual exclusion: select_initial, select_update, fwd_en and bwd_en are pairwise exclusive in every cycle.
- Indices are never wrapped. Counter widths come from the parameters; no arithmetic overflow is possible.
- IDLE after DONE: indices retain their final values until the next INIT.

Decomposition:
- Shared package nn_pkg holds the state encoding constants (3-bit: IDLE=0, INIT=1, FWD=2, BWD=3, UPD=4, DONE=5). It also holds the default sample/epoch counts used by the network top.
- One sub-module is natural: phase_cnt, a loadable down-counter with a zero flag, used for the FWD/BWD dwell.
- Index counters stay inline.

Test Plan:
Use parameters N_SAMPLES=4, N_EPOCHS=2, FWD=3, BWD=4.
1. Reset then start pulse at edge 0 -> select_initial=1 in cycle 1 only; fwd_en cycles 2-4; bwd_en cycles 5-8; select_update cycle 9; sample_idx=1 in cycle 10.
2. Full run -> exactly 8 select_update pulses; epoch_idx goes 0 to 1 after the 4th pulse; done pulses once in cycle 66; busy falls in cycle 67; final sample_idx=3, epoch_idx=1.
3. stop=1 sampled during the 2nd BWD cycle of sample 2 -> IDLE next cycle; indices 0; no further select_update; done never asserted.
4. Assert reset asynchronously mid-FWD (between edges) -> all outputs 0 immediately, before the next edge; start after release -> normal INIT.
5. start held high continuously through a run -> no restart until IDLE is reached; then INIT begins one cycle after the IDLE cycle. start and stop together in IDLE -> stays IDLE.
6. Every cycle of every test -> assertion that at most one of select_initial/select_update/fwd_en/bwd_en is high; busy equals (state != IDLE).

Source files
------------

// File: rtl/nn_train_seq_pkg.sv
// Shared definitions for the backprop training sequencer: state encoding,
// default network sizes and a counter-width helper.
package nn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_FWD  = 3'd2,
        ST_BWD  = 3'd3,
        ST_UPD  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam int NN_N_SAMPLES = 4;
    localparam int NN_N_EPOCHS  = 1000;

    // Bits needed to hold 0..max_val-1, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/nn_train_seq_if.sv
// Control/status bundle between the top-level start/done logic and the
// training sequencer.
interface nn_train_seq_if #(
    parameter int SAMPLE_W = 2,
    parameter int EPOCH_W  = 10
);
    logic                start;
    logic                stop;
    logic                select_initial;
    logic                select_update;
    logic                fwd_en;
    logic                bwd_en;
    logic [SAMPLE_W-1:0] sample_idx;
    logic [EPOCH_W-1:0]  epoch_idx;
    logic                busy;
    logic                done;

    modport master (
        output start, stop,
        input  select_initial, select_update, fwd_en, bwd_en,
               sample_idx, epoch_idx, busy, done
    );

    modport slave (
        input  start, stop,
        output select_initial, select_update, fwd_en, bwd_en,
               sample_idx, epoch_idx, busy, done
    );
endinterface

// File: rtl/nn_train_seq_phase_cnt.sv
// Loadable down-counter with zero flag; times the forward/backward dwell.
module phase_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  cnt <= '0;
        else if (load)              cnt <= load_val;
        else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/nn_train_seq.sv
// Training sequencer: INIT, then FWD/BWD/UPD per sample for every epoch, then
// a one-cycle DONE. All outputs are registered decodes of the next state.
module nn_train_seq
    import nn_pkg::*;
#(
    parameter int N_SAMPLES  = NN_N_SAMPLES,
    parameter int N_EPOCHS   = NN_N_EPOCHS,
    parameter int FWD_CYCLES = 3,
    parameter int BWD_CYCLES = 4,
    parameter int SAMPLE_W   = 2,
    parameter int EPOCH_W    = 10
) (
    input  logic          clk,
    input  logic          reset,
    nn_train_seq_if.slave bus
);
    localparam int PH_MAX = (FWD_CYCLES > BWD_CYCLES) ? FWD_CYCLES : BWD_CYCLES;
    localparam int PH_W   = cnt_width(PH_MAX);

    localparam logic [PH_W-1:0]     FWD_LD   = PH_W'(FWD_CYCLES - 1);
    localparam logic [PH_W-1:0]     BWD_LD   = PH_W'(BWD_CYCLES - 1);
    localparam logic [SAMPLE_W-1:0] SMP_LAST = SAMPLE_W'(N_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0]  EP_LAST  = EPOCH_W'(N_EPOCHS - 1);

    state_t              state, state_nx;
    logic [SAMPLE_W-1:0] sample_q, sample_nx;
    logic [EPOCH_W-1:0]  epoch_q, epoch_nx;
    logic                ph_load, ph_dec, ph_zero;
    logic [PH_W-1:0]     ph_load_val;
    logic                sel_init_q, sel_upd_q, fwd_q, bwd_q, busy_q, done_q;

    phase_cnt #(.W(PH_W)) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (ph_load),
        .load_val (ph_load_val),
        .dec      (ph_dec),
        .zero     (ph_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        sample_nx   = sample_q;
        epoch_nx    = epoch_q;
        ph_load     = 1'b0;
        ph_load_val = '0;
        ph_dec      = 1'b0;
        if (state != ST_IDLE && bus.stop) begin
            // Abort: indices cleared, any pending increment from UPD dropped.
            state_nx  = ST_IDLE;
            sample_nx = '0;
            epoch_nx  = '0;
            ph_load   = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: if (bus.start && !bus.stop) begin
                    state_nx  = ST_INIT;
                    sample_nx = '0;
                    epoch_nx  = '0;
                end
                ST_INIT: begin
                    state_nx    = ST_FWD;
                    ph_load     = 1'b1;
                    ph_load_val = FWD_LD;
                end
                ST_FWD: if (ph_zero) begin
                    state_nx    = ST_BWD;
                    ph_load     = 1'b1;
                    ph_load_val = BWD_LD;
                end else begin
                    ph_dec = 1'b1;
                end
                ST_BWD: if (ph_zero) state_nx = ST_UPD;
                        else         ph_dec   = 1'b1;
                ST_UPD: begin
                    if (sample_q < SMP_LAST) begin
                        state_nx  = ST_FWD;
                        sample_nx = sample_q + 1'b1;
                    end else if (epoch_q < EP_LAST) begin
                        state_nx  = ST_FWD;
                        sample_nx = '0;
                        epoch_nx  = epoch_q + 1'b1;
                    end else begin
                        state_nx  = ST_DONE;
                    end
                    ph_load     = (state_nx == ST_FWD);
                    ph_load_val = FWD_LD;
                end
                ST_DONE: state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q   <= '0;
            epoch_q    <= '0;
            sel_init_q <= 1'b0;
            sel_upd_q  <= 1'b0;
            fwd_q      <= 1'b0;
            bwd_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            sample_q   <= sample_nx;
            epoch_q    <= epoch_nx;
            sel_init_q <= (state_nx == ST_INIT);
            sel_upd_q  <= (state_nx == ST_UPD);
            fwd_q      <= (state_nx == ST_FWD);
            bwd_q      <= (state_nx == ST_BWD);
            busy_q     <= (state_nx != ST_IDLE);
            done_q     <= (state_nx == ST_DONE);
        end
    end

    assign bus.select_initial = sel_init_q;
    assign bus.select_update  = sel_upd_q;
    assign bus.fwd_en         = fwd_q;
    assign bus.bwd_en         = bwd_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.sample_idx     = sample_q;
    assign bus.epoch_idx      = epoch_q;
endmodule
